esc_arm_sequencer: RTL
======================

// Module: esc_arm_sequencer
// PURPOSE
//  Sequences the quad ESC bank: owns the periodic wrt strobe, motors_off and the four speed buses.
//  Sits between the flight-control loop and the four-channel ESC bank.
//  Implements arm delay, soft-start ramp, command-loss failsafe ramp-down and immediate disarm.
//  All outputs are registered.
// PARAMETERS
//  UPDATE_CYCLES    125000  clk cycles per ESC update period (tick period)
//  ARM_UPDATES      400     ticks held at zero speed, motors enabled, before ramp starts
//  RAMP_STEP        8       11-bit ceiling increment / speed decrement per tick
//  TIMEOUT_UPDATES  40      ticks without cmd_vld (in RAMP/RUN) that trigger failsafe LAND
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  arm        in   1   arm request, sampled only in IDLE
//  disarm     in   1   disarm request, any state; priority over arm
//  cmd_vld    in   1   1-cycle strobe: capture cmd_* speeds
//  cmd_frnt   in   11  commanded front speed
//  cmd_bck    in   11  commanded back speed
//  cmd_lft    in   11  commanded left speed
//  cmd_rght   in   11  commanded right speed
//  frnt_spd   out  11  speed to ESC bank, front
//  bck_spd    out  11  speed to ESC bank, back
//  lft_spd    out  11  speed to ESC bank, left
//  rght_spd   out  11  speed to ESC bank, right
//  wrt        out  1   1-cycle ESC update strobe
//  motors_off out  1   forces ESC bank speeds to zero
//  state      out  3   IDLE=0 ARM=1 RAMP=2 RUN=3 LAND=4
//  failsafe   out  1   sticky: LAND entered via timeout; cleared on IDLE->ARM
// BEHAVIOUR
//  Reset (synchronous, rst=1):
//   state=IDLE; all *_spd=0; motors_off=1; wrt=0; failsafe=0; tick, arm and timeout counters=0; ceil=0; cmd regs=0.
//  Tick:
//   - Free-running counter 0..UPDATE_CYCLES-1; tick=1 when counter==UPDATE_CYCLES-1.
//   - Counter runs in every state.
//   - *_spd regs load on the tick edge; wrt asserts on the following cycle, one cycle wide.
//   - *_spd are stable for UPDATE_CYCLES-1 cycles around each wrt.
//  Command capture:
//   - cmd_vld loads the cmd regs. A capture on a tick cycle affects the next tick, not this one.
//   - cmd_vld clears the timeout count; otherwise each tick in RAMP/RUN increments it.
//   - cmd_vld and tick in the same cycle: the clear wins.
//  FSM (transitions on clock edge; disarm checked first in every state):
//   - disarm=1: next state IDLE. motors_off=1, *_spd=0 at that same edge; ceil and counters cleared; failsafe kept.
//   - IDLE: motors_off=1, spd=0.
//     arm=1 -> ARM: motors_off=0, arm count=0, failsafe=0, timeout=0.
//   - ARM: spd=0. Each tick increments the arm count.
//     On the tick reaching ARM_UPDATES -> RAMP with ceil=0.
//   - RAMP: on each tick, ceil=min(ceil+RAMP_STEP, 2047) (12-bit add, saturate) and spd=min(cmd, new ceil) per channel.
//     When the new ceil==2047 -> RUN.
//   - RUN: on each tick, spd=cmd.
//   - RAMP/RUN timeout: on the tick where the count reaches TIMEOUT_UPDATES -> LAND, failsafe=1.
//     That tick applies the LAND decrement, not a ramp/run load.
//   - LAND: cmd ignored. On each tick, spd=max(spd-RAMP_STEP, 0) per channel.
//     When all four spd==0 after the update -> IDLE, motors_off=1.
//     cmd_vld does not leave LAND.
//  Boundaries:
//   - arm outside IDLE: ignored.
//   - arm and disarm in the same cycle: disarm wins.
//   - wrt keeps pulsing in IDLE with spd=0.
//   - rst mid-ramp or mid-LAND: immediate reset values on the next edge; no partial ramp.
//   - Speeds never exceed 2047 and never underflow.
// TESTING (UPDATE_CYCLES=10, ARM_UPDATES=3, RAMP_STEP=512, TIMEOUT_UPDATES=4)
//  1. rst=1 for 2 clk -> state=0, motors_off=1, all spd=0, wrt pulses every 10 clk, one clk after each tick.
//  2. arm pulse, cmd=2047 on all channels, cmd_vld every tick -> motors_off=0, 3 ticks at spd=0,
//     then spd 512, 1024, 1536, 2047, then state=RUN.
//  3. In RUN, cmd_frnt=300 with cmd_vld -> frnt_spd=300 at the next tick; wrt exactly one clk after the load.
//  4. In RUN (frnt=300, others 1000), stop cmd_vld -> LAND on 4th tick, failsafe=1.
//     frnt 300->0, others 1000->488->0; then IDLE, motors_off=1.
//  5. disarm mid-RAMP with spd=1024 -> next edge state=IDLE, spd=0, motors_off=1.
//     Same-cycle arm+disarm in IDLE stays in IDLE.
//  6. cmd_vld coincident with a tick and with the timeout limit -> no LAND; new cmd appears on the following tick.

Source files
------------

// File: rtl/esc_arm_sequencer_if.sv
// Flight-control <-> ESC sequencer bundle: arm/disarm, speed commands in, ESC bank drive out.
interface esc_arm_sequencer_if;
  localparam int unsigned SPD_W = 11;

  logic             arm;
  logic             disarm;
  logic             cmd_vld;
  logic [SPD_W-1:0] cmd_frnt;
  logic [SPD_W-1:0] cmd_bck;
  logic [SPD_W-1:0] cmd_lft;
  logic [SPD_W-1:0] cmd_rght;
  logic [SPD_W-1:0] frnt_spd;
  logic [SPD_W-1:0] bck_spd;
  logic [SPD_W-1:0] lft_spd;
  logic [SPD_W-1:0] rght_spd;
  logic             wrt;
  logic             motors_off;
  logic [2:0]       state;
  logic             failsafe;

  modport master (
    output arm, disarm, cmd_vld, cmd_frnt, cmd_bck, cmd_lft, cmd_rght,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, wrt, motors_off, state, failsafe
  );

  modport slave (
    input  arm, disarm, cmd_vld, cmd_frnt, cmd_bck, cmd_lft, cmd_rght,
    output frnt_spd, bck_spd, lft_spd, rght_spd, wrt, motors_off, state, failsafe
  );
endinterface

// File: rtl/esc_arm_sequencer.sv
// Quad ESC sequencer: periodic wrt strobe, arm delay, soft-start ramp,
// command-loss failsafe ramp-down and immediate disarm. All outputs registered.
module esc_arm_sequencer #(
  parameter int unsigned UPDATE_CYCLES   = 125000,
  parameter int unsigned ARM_UPDATES     = 400,
  parameter int unsigned RAMP_STEP       = 8,
  parameter int unsigned TIMEOUT_UPDATES = 40
) (
  input logic                clk,
  input logic                rst,
  esc_arm_sequencer_if.slave bus
);
  localparam int unsigned   SW      = 11;
  localparam int unsigned   TCW     = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam int unsigned   ACW     = $clog2(ARM_UPDATES + 1);
  localparam int unsigned   TOW     = $clog2(TIMEOUT_UPDATES + 1);
  localparam logic [SW-1:0] SPD_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RAMP = 3'd2,
    S_RUN  = 3'd3,
    S_LAND = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TCW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [ACW-1:0]     arm_cnt_q, arm_cnt_d;
  logic [TOW-1:0]     to_cnt_q, to_cnt_d;
  logic [SW-1:0]      ceil_q, ceil_d;
  logic [3:0][SW-1:0] spd_q, spd_d;
  logic [3:0][SW-1:0] cmd_q, cmd_d;
  logic               wrt_q, wrt_d;
  logic               motors_off_q, motors_off_d;
  logic               failsafe_q, failsafe_d;

  logic               tick;
  logic               active;
  logic               timeout_hit;
  logic               arm_done;
  logic [SW:0]        ceil_sum;
  logic [SW-1:0]      ceil_sat;
  logic [3:0][SW-1:0] cmd_in;
  logic [3:0][SW-1:0] spd_dec;
  logic [3:0][SW-1:0] spd_ramp;

  assign cmd_in      = {bus.cmd_rght, bus.cmd_lft, bus.cmd_bck, bus.cmd_frnt};
  assign tick        = (tick_cnt_q == TCW'(UPDATE_CYCLES - 1));
  assign active      = (state_q == S_RAMP) || (state_q == S_RUN);
  assign timeout_hit = tick && active && !bus.cmd_vld &&
                       ((to_cnt_q + TOW'(1)) == TOW'(TIMEOUT_UPDATES));
  assign arm_done    = ((arm_cnt_q + ACW'(1)) == ACW'(ARM_UPDATES));
  assign ceil_sum    = {1'b0, ceil_q} + (SW+1)'(RAMP_STEP);
  assign ceil_sat    = (ceil_sum > {1'b0, SPD_MAX}) ? SPD_MAX : ceil_sum[SW-1:0];

  // Per-channel saturating land decrement and ceiling-limited ramp load
  always_comb begin
    spd_dec  = '0;
    spd_ramp = '0;
    for (int i = 0; i < 4; i++) begin
      spd_dec[i]  = ({1'b0, spd_q[i]} > (SW+1)'(RAMP_STEP)) ? (spd_q[i] - SW'(RAMP_STEP)) : '0;
      spd_ramp[i] = (cmd_q[i] < ceil_sat) ? cmd_q[i] : ceil_sat;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : (tick_cnt_q + TCW'(1));
    arm_cnt_d    = arm_cnt_q;
    to_cnt_d     = to_cnt_q;
    ceil_d       = ceil_q;
    spd_d        = spd_q;
    cmd_d        = bus.cmd_vld ? cmd_in : cmd_q;
    wrt_d        = tick;
    motors_off_d = motors_off_q;
    failsafe_d   = failsafe_q;

    // A fresh command always clears the loss counter, even on the limit tick
    if (bus.cmd_vld) begin
      to_cnt_d = '0;
    end else if (tick && active) begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end

    if (bus.disarm) begin
      state_d      = S_IDLE;
      spd_d        = '0;
      motors_off_d = 1'b1;
      ceil_d       = '0;
      arm_cnt_d    = '0;
      to_cnt_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            state_d      = S_ARM;
            motors_off_d = 1'b0;
            arm_cnt_d    = '0;
            failsafe_d   = 1'b0;
            to_cnt_d     = '0;
          end
        end
        S_ARM: begin
          if (tick) begin
            spd_d     = '0;
            arm_cnt_d = arm_cnt_q + ACW'(1);
            if (arm_done) begin
              state_d = S_RAMP;
              ceil_d  = '0;
            end
          end
        end
        S_RAMP: begin
          if (timeout_hit) begin
            state_d    = S_LAND;
            failsafe_d = 1'b1;
            spd_d      = spd_dec;
          end else if (tick) begin
            ceil_d = ceil_sat;
            spd_d  = spd_ramp;
            if (ceil_sat == SPD_MAX) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (timeout_hit) begin
            state_d    = S_LAND;
            failsafe_d = 1'b1;
            spd_d      = spd_dec;
          end else if (tick) begin
            spd_d = cmd_q;
          end
        end
        S_LAND: begin
          if (tick) begin
            spd_d = spd_dec;
            if (spd_dec == '0) begin
              state_d      = S_IDLE;
              motors_off_d = 1'b1;
            end
          end
        end
        default: begin
          state_d      = S_IDLE;
          spd_d        = '0;
          motors_off_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      arm_cnt_q    <= '0;
      to_cnt_q     <= '0;
      ceil_q       <= '0;
      spd_q        <= '0;
      cmd_q        <= '0;
      wrt_q        <= 1'b0;
      motors_off_q <= 1'b1;
      failsafe_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      arm_cnt_q    <= arm_cnt_d;
      to_cnt_q     <= to_cnt_d;
      ceil_q       <= ceil_d;
      spd_q        <= spd_d;
      cmd_q        <= cmd_d;
      wrt_q        <= wrt_d;
      motors_off_q <= motors_off_d;
      failsafe_q   <= failsafe_d;
    end
  end

  assign bus.frnt_spd   = spd_q[0];
  assign bus.bck_spd    = spd_q[1];
  assign bus.lft_spd    = spd_q[2];
  assign bus.rght_spd   = spd_q[3];
  assign bus.wrt        = wrt_q;
  assign bus.motors_off = motors_off_q;
  assign bus.state      = state_q;
  assign bus.failsafe   = failsafe_q;
endmodule
